// File: rtl/seq_mult_8x8_pkg.sv
// rtl/seq_mult_8x8_pkg.sv - shared widths and state encoding for the sequential multiplier
package seq_mult_8x8_pkg;

    localparam int OPW   = 8;
    localparam int PRODW = 16;
    localparam int ITER  = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [2:0] LAST_CNT = 3'(ITER - 1);

endpackage

// File: rtl/seq_mult_8x8_and_8x1.sv
// rtl/seq_mult_8x8_and_8x1.sv - And_8x1 partial-product gate: 8-bit word ANDed with one bit
module And_8x1
    import seq_mult_8x8_pkg::*;
(
    input  logic [OPW-1:0] in8bit,
    input  logic           in1bit,
    output logic [OPW-1:0] out8bit
);

    assign out8bit = in8bit & {OPW{in1bit}};

endmodule

// File: rtl/seq_mult_8x8.sv
// rtl/seq_mult_8x8.sv - 8x8 unsigned shift-and-add multiplier, one multiplier bit per cycle
module seq_mult_8x8
    import seq_mult_8x8_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [OPW-1:0]   a,
    input  logic [OPW-1:0]   b,
    output logic             busy,
    output logic             done,
    output logic [PRODW-1:0] product
);

    state_t           state_q;
    logic [OPW-1:0]   mcand_q;
    logic [OPW-1:0]   mplier_q;
    logic [PRODW-1:0] acc_q;
    logic [2:0]       cnt_q;
    logic [PRODW-1:0] product_q;
    logic             busy_q;
    logic             done_q;

    logic [OPW-1:0]   pp;
    logic [OPW:0]     sum;
    logic [PRODW-1:0] acc_d;

    And_8x1 u_and_8x1 (
        .in8bit  (mcand_q),
        .in1bit  (mplier_q[0]),
        .out8bit (pp)
    );

    // The carry out of the upper-half add becomes acc[15] after the shift.
    assign sum   = {1'b0, acc_q[PRODW-1:OPW]} + {1'b0, pp};
    assign acc_d = {sum, acc_q[OPW-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    acc_q    <= acc_d;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 3'd1;
                    if (cnt_q == LAST_CNT) begin
                        product_q <= acc_d;
                        state_q   <= ST_DONE;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                // Idle, and the unused encoding, which behaves as idle.
                default: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    if (state_q != ST_IDLE) begin
                        state_q <= ST_IDLE;
                    end
                    if (start) begin
                        mcand_q  <= a;
                        mplier_q <= b;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        state_q  <= ST_RUN;
                        busy_q   <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_seq_mult_8x8.sv
// tb/tb_seq_mult_8x8.sv - self-checking bench for seq_mult_8x8
module tb_seq_mult_8x8;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        busy;
    logic        done;
    logic [15:0] product;

    int total = 0;
    int bad   = 0;
    logic [15:0] last_prod;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[5];

    seq_mult_8x8 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called one step after an edge while idle; ends one step after the edge that returns to idle.
    task automatic run_op(input string name, input logic [7:0] av, input logic [7:0] bv,
                          input logic [15:0] exp);
        int  cyc;
        bit  got;
        start = 1'b1;
        a     = av;
        b     = bv;
        tick();
        start = 1'b0;
        a     = 8'($urandom);
        b     = 8'($urandom);
        check({name, " busy_after_accept"}, 32'(busy), 32'd1);
        cyc = 0;
        got = 0;
        while (cyc < 20 && !got) begin
            tick();
            cyc++;
            if (done) begin
                got = 1;
            end else begin
                check({name, " busy_in_run"}, 32'(busy), 32'd1);
                check({name, " product_held"}, 32'(product), 32'(last_prod));
            end
        end
        check({name, " done_seen"}, 32'(got), 32'd1);
        check({name, " latency"}, 32'(cyc), 32'd8);
        check({name, " product"}, 32'(product), 32'(exp));
        check({name, " busy_in_done"}, 32'(busy), 32'd0);
        tick();
        check({name, " done_one_cycle"}, 32'(done), 32'd0);
        check({name, " product_kept"}, 32'(product), 32'(exp));
        last_prod = exp;
    endtask

    initial begin
        int  cyc;
        bit  got;
        logic [7:0] ra;
        logic [7:0] rb;

        vecs[0] = '{a: 8'h0F, b: 8'h0F, exp: 16'h00E1};
        vecs[1] = '{a: 8'hFF, b: 8'hFF, exp: 16'hFE01};
        vecs[2] = '{a: 8'h00, b: 8'hA5, exp: 16'h0000};
        vecs[3] = '{a: 8'h80, b: 8'h02, exp: 16'h0100};
        vecs[4] = '{a: 8'h03, b: 8'h05, exp: 16'h000F};

        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        last_prod = 16'h0000;
        repeat (3) tick();
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset product", 32'(product), 32'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 4; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].exp);
        end

        // Start during RUN is ignored; held high through DONE it is taken once idle again.
        start = 1'b1;
        a     = 8'h21;
        b     = 8'h43;
        tick();
        a     = 8'h12;
        b     = 8'h34;
        cyc = 0;
        got = 0;
        while (cyc < 20 && !got) begin
            tick();
            cyc++;
            if (done) got = 1;
        end
        check("ignore first_done_latency", 32'(cyc), 32'd8);
        check("ignore first_product", 32'(product), 32'(16'h21 * 16'h43));
        cyc = 0;
        got = 0;
        while (cyc < 30 && !got) begin
            tick();
            cyc++;
            if (cyc == 2) start = 1'b0;
            if (done) got = 1;
        end
        start = 1'b0;
        check("backtoback done_seen", 32'(got), 32'd1);
        check("backtoback interval", 32'(cyc), 32'd10);
        check("backtoback product", 32'(product), 32'(16'h12 * 16'h34));
        tick();
        last_prod = 16'h12 * 16'h34;

        // Reset in the middle of a run.
        start = 1'b1;
        a     = 8'h55;
        b     = 8'h66;
        tick();
        start = 1'b0;
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        check("midreset busy", 32'(busy), 32'd0);
        check("midreset done", 32'(done), 32'd0);
        check("midreset product", 32'(product), 32'd0);
        tick();
        check("midreset stays_idle", 32'(busy), 32'd0);
        #2;
        rst_n = 1'b1;
        last_prod = 16'h0000;
        tick();
        check("after_reset idle", 32'(busy), 32'd0);
        run_op("vec4", vecs[4].a, vecs[4].b, vecs[4].exp);

        for (int i = 0; i < 200; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            run_op($sformatf("rand%0d", i), ra, rb, 16'(ra) * 16'(rb));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
